mc_controller_ws: RTL and testbench



---
 rtl/mc_controller_ws.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_controller_ws.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_ws.sv
// Multi-cycle RV32I/F core controller with a parametrised fetch latency, a DM
// req/ack handshake guarded by a timeout, and a saturating retired-instruction counter.
module mc_controller_ws #(
  parameter int unsigned FETCH_WAIT = 1,
  parameter int unsigned DM_TIMEOUT = 15,
  parameter int unsigned ICNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [6:0]        i_opcode,
  input  logic [6:0]        i_func7,
  input  logic [2:0]        i_func3,
  input  logic              i_invalid_pc,
  input  logic              i_invalid_alu,
  input  logic              i_branch_cond,
  input  logic              i_dm_ack,
  output logic              o_mem_sel,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic              o_rd_wen,
  output logic              o_fd_wen,
  output logic              o_lw_sel,
  output logic              o_reg_i_en,
  output logic              o_reg_d_en,
  output logic              o_reg_a_en,
  output logic              o_reg_n_en,
  output logic              o_imm_rf2_sel,
  output logic [6:0]        o_opcode,
  output logic [6:0]        o_func7,
  output logic [2:0]        o_func3,
  output logic              o_branch,
  output logic [2:0]        o_status,
  output logic              o_status_valid,
  output logic [ICNT_W-1:0] o_retired
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpFp     = 7'b1010011;
  localparam logic [6:0] OpAddi   = 7'b0010011;
  localparam logic [6:0] OpLw     = 7'b0000011;
  localparam logic [6:0] OpFlw    = 7'b0000111;
  localparam logic [6:0] OpSw     = 7'b0100011;
  localparam logic [6:0] OpFsw    = 7'b0100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpEof    = 7'b1110011;

  localparam logic [6:0] F7Fadd   = 7'b0000000;
  localparam logic [6:0] F7Fsub   = 7'b0000100;
  localparam logic [6:0] F7Fclass = 7'b1110000;
  localparam logic [6:0] F7Flt    = 7'b1010000;

  // Status codes; 0 means "no recognised type".
  localparam logic [2:0] TypeNone    = 3'd0;
  localparam logic [2:0] TypeR       = 3'd1;
  localparam logic [2:0] TypeI       = 3'd2;
  localparam logic [2:0] TypeS       = 3'd3;
  localparam logic [2:0] TypeB       = 3'd4;
  localparam logic [2:0] TypeInvalid = 3'd5;
  localparam logic [2:0] TypeEof     = 3'd6;

  localparam logic [3:0] FetchLast = 4'(FETCH_WAIT);
  localparam logic [7:0] TmoLast   = 8'(DM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StNextPc, StEnd
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          fetch_cnt_q, fetch_cnt_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic [6:0]          opcode_q, opcode_d;
  logic [6:0]          func7_q, func7_d;
  logic [2:0]          func3_q, func3_d;
  logic                branch_q, branch_d;
  logic [2:0]          end_status_q, end_status_d;
  logic [ICNT_W-1:0]   retired_q, retired_d;

  // Decode of the latched fields only.
  logic       is_load, is_store, is_fp, store_wen, rd_op, fd_op;
  logic [2:0] op_type;

  assign is_load   = (opcode_q == OpLw) || (opcode_q == OpFlw);
  assign is_store  = (opcode_q == OpSw) || (opcode_q == OpFsw);
  assign is_fp     = (opcode_q == OpFp);
  assign store_wen = is_store && (func3_q == 3'b010);
  assign rd_op     = (opcode_q == OpR) || (opcode_q == OpAddi) || (opcode_q == OpLw) ||
                     (is_fp && (func3_q == 3'b001) &&
                      ((func7_q == F7Fclass) || (func7_q == F7Flt)));
  assign fd_op     = (opcode_q == OpFlw) ||
                     (is_fp && (func3_q == 3'b000) &&
                      ((func7_q == F7Fadd) || (func7_q == F7Fsub)));

  // Instruction class reported on the status port.
  always_comb begin
    op_type = TypeNone;
    case (opcode_q)
      OpR, OpFp:             op_type = TypeR;
      OpAddi, OpLw, OpFlw:   op_type = TypeI;
      OpSw, OpFsw:           op_type = TypeS;
      OpBranch:              op_type = TypeB;
      default:               op_type = TypeNone;
    endcase
  end

  // Datapath-facing decode outputs, driven purely from the latched instruction.
  assign o_opcode      = opcode_q;
  assign o_func7       = func7_q;
  assign o_func3       = func3_q;
  assign o_lw_sel      = is_load;
  assign o_imm_rf2_sel = (opcode_q == OpR) || is_fp || (opcode_q == OpBranch);
  assign o_branch      = (state_q == StNextPc) && branch_q && (opcode_q == OpBranch);
  assign o_retired     = retired_q;

  // Next-state, counters, latches and per-state control outputs.
  always_comb begin
    state_d        = state_q;
    fetch_cnt_d    = fetch_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    opcode_d       = opcode_q;
    func7_d        = func7_q;
    func3_d        = func3_q;
    branch_d       = branch_q;
    end_status_d   = end_status_q;
    retired_d      = retired_q;
    o_mem_sel      = 1'b0;
    o_mem_req      = 1'b0;
    o_mem_wen      = 1'b0;
    o_rd_wen       = 1'b0;
    o_fd_wen       = 1'b0;
    o_reg_i_en     = 1'b0;
    o_reg_d_en     = 1'b0;
    o_reg_a_en     = 1'b0;
    o_reg_n_en     = 1'b0;
    o_status       = TypeNone;
    o_status_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        fetch_cnt_d = 4'd0;
        state_d     = StFetch;
      end
      StFetch: begin
        if (fetch_cnt_q == FetchLast) begin
          o_reg_i_en = 1'b1;
          state_d    = StDecode;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 4'd1;
        end
      end
      StDecode: begin
        o_reg_d_en = 1'b1;
        opcode_d   = i_opcode;
        func7_d    = i_func7;
        func3_d    = i_func3;
        state_d    = StExec;
      end
      StExec: begin
        o_reg_a_en = 1'b1;
        branch_d   = i_branch_cond;
        if (i_invalid_alu) begin
          end_status_d = TypeInvalid;
          state_d      = StEnd;
        end else if (opcode_q == OpEof) begin
          end_status_d = TypeEof;
          state_d      = StEnd;
        end else if (is_load || is_store) begin
          tmo_cnt_d = 8'd0;
          state_d   = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        o_mem_sel = 1'b1;
        o_mem_req = 1'b1;
        o_mem_wen = store_wen;
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (i_dm_ack) begin
          state_d = StWb;
        end else if (tmo_cnt_q == TmoLast) begin
          end_status_d = TypeInvalid;
          state_d      = StEnd;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StWb: begin
        o_rd_wen = rd_op;
        o_fd_wen = fd_op;
        state_d  = StNextPc;
      end
      StNextPc: begin
        o_reg_n_en = 1'b1;
        o_status   = op_type;
        if (!i_invalid_pc) begin
          o_status_valid = 1'b1;
          if (!(&retired_q)) begin
            retired_d = retired_q + 1'b1;
          end
          fetch_cnt_d = 4'd0;
          state_d     = StFetch;
        end else begin
          end_status_d = TypeInvalid;
          state_d      = StEnd;
        end
      end
      StEnd: begin
        o_status       = end_status_q;
        o_status_valid = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      fetch_cnt_q  <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      opcode_q     <= 7'd0;
      func7_q      <= 7'd0;
      func3_q      <= 3'd0;
      branch_q     <= 1'b0;
      end_status_q <= TypeNone;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_cnt_q  <= fetch_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      opcode_q     <= opcode_d;
      func7_q      <= func7_d;
      func3_q      <= func3_d;
      branch_q     <= branch_d;
      end_status_q <= end_status_d;
      retired_q    <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Self-checking bench for mc_controller_ws: table of instruction classes, directed
// corner sequences, and randomized instruction streams against a transaction-level model.
module tb_mc_controller_ws;

  localparam int unsigned FW_A  = 1;
  localparam int unsigned DMT_A = 4;
  localparam int unsigned ICW_A = 4;
  localparam int unsigned FW_B  = 3;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_FP   = 7'b1010011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_FLW  = 7'b0000111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_FSW  = 7'b0100111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_EOF  = 7'b1110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_R    = 3'd1;
  localparam logic [2:0] ST_I    = 3'd2;
  localparam logic [2:0] ST_S    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_INV  = 3'd5;
  localparam logic [2:0] ST_EOF  = 3'd6;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct packed {
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       mem;
    logic       wen;
    logic       rd;
    logic       fd;
    logic       lws;
    logic       rf2;
    logic [2:0] st;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = '0, i_func7 = '0;
  logic [2:0] i_func3 = '0;
  logic       i_invalid_pc = 1'b0, i_invalid_alu = 1'b0, i_branch_cond = 1'b0, i_dm_ack = 1'b0;

  logic o_mem_sel, o_mem_req, o_mem_wen, o_rd_wen, o_fd_wen, o_lw_sel;
  logic o_reg_i_en, o_reg_d_en, o_reg_a_en, o_reg_n_en, o_imm_rf2_sel, o_branch;
  logic [6:0] o_opcode, o_func7;
  logic [2:0] o_func3, o_status;
  logic o_status_valid;
  logic [ICW_A-1:0] o_retired;

  logic b_mem_sel, b_mem_req, b_mem_wen, b_rd_wen, b_fd_wen, b_lw_sel;
  logic b_reg_i_en, b_reg_d_en, b_reg_a_en, b_reg_n_en, b_imm_rf2_sel, b_branch;
  logic [6:0] b_opcode, b_func7;
  logic [2:0] b_func3, b_status;
  logic b_status_valid;
  logic [15:0] b_retired;

  mc_controller_ws #(.FETCH_WAIT(FW_A), .DM_TIMEOUT(DMT_A), .ICNT_W(ICW_A)) u_dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_func7(i_func7), .i_func3(i_func3),
    .i_invalid_pc(i_invalid_pc), .i_invalid_alu(i_invalid_alu),
    .i_branch_cond(i_branch_cond), .i_dm_ack(i_dm_ack),
    .o_mem_sel(o_mem_sel), .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen),
    .o_rd_wen(o_rd_wen), .o_fd_wen(o_fd_wen), .o_lw_sel(o_lw_sel),
    .o_reg_i_en(o_reg_i_en), .o_reg_d_en(o_reg_d_en), .o_reg_a_en(o_reg_a_en),
    .o_reg_n_en(o_reg_n_en), .o_imm_rf2_sel(o_imm_rf2_sel), .o_opcode(o_opcode),
    .o_func7(o_func7), .o_func3(o_func3), .o_branch(o_branch), .o_status(o_status),
    .o_status_valid(o_status_valid), .o_retired(o_retired)
  );

  // Second instance only exercises the longer fetch latency.
  mc_controller_ws #(.FETCH_WAIT(FW_B), .DM_TIMEOUT(15), .ICNT_W(16)) u_dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_func7(i_func7), .i_func3(i_func3),
    .i_invalid_pc(i_invalid_pc), .i_invalid_alu(i_invalid_alu),
    .i_branch_cond(i_branch_cond), .i_dm_ack(i_dm_ack),
    .o_mem_sel(b_mem_sel), .o_mem_req(b_mem_req), .o_mem_wen(b_mem_wen),
    .o_rd_wen(b_rd_wen), .o_fd_wen(b_fd_wen), .o_lw_sel(b_lw_sel),
    .o_reg_i_en(b_reg_i_en), .o_reg_d_en(b_reg_d_en), .o_reg_a_en(b_reg_a_en),
    .o_reg_n_en(b_reg_n_en), .o_imm_rf2_sel(b_imm_rf2_sel), .o_opcode(b_opcode),
    .o_func7(b_func7), .o_func3(b_func3), .o_branch(b_branch), .o_status(b_status),
    .o_status_valid(b_status_valid), .o_retired(b_retired)
  );

  int total = 0;
  int bad = 0;
  int exp_ret = 0;
  vec_t tbl [15];

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chkv(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Reference rules for one instruction, straight from the opcode/func tables.
  function automatic vec_t ref_vec(input logic [6:0] op, input logic [6:0] f7,
                                   input logic [2:0] f3);
    vec_t v;
    v.op  = op;
    v.f7  = f7;
    v.f3  = f3;
    v.mem = (op == OP_LW) || (op == OP_FLW) || (op == OP_SW) || (op == OP_FSW);
    v.wen = ((op == OP_SW) || (op == OP_FSW)) && (f3 == 3'b010);
    v.lws = (op == OP_LW) || (op == OP_FLW);
    v.rf2 = (op == OP_R) || (op == OP_FP) || (op == OP_B);
    v.rd  = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
            ((op == OP_FP) && (f3 == 3'b001) && ((f7 == 7'b1110000) || (f7 == 7'b1010000)));
    v.fd  = (op == OP_FLW) ||
            ((op == OP_FP) && (f3 == 3'b000) && ((f7 == 7'b0000000) || (f7 == 7'b0000100)));
    if ((op == OP_R) || (op == OP_FP)) v.st = ST_R;
    else if ((op == OP_ADDI) || (op == OP_LW) || (op == OP_FLW)) v.st = ST_I;
    else if ((op == OP_SW) || (op == OP_FSW)) v.st = ST_S;
    else if (op == OP_B) v.st = ST_B;
    else v.st = ST_NONE;
    return v;
  endfunction

  task automatic noise();
    i_opcode      = 7'($urandom);
    i_func7       = 7'($urandom);
    i_func3       = 3'($urandom);
    i_invalid_alu = 1'($urandom);
    i_invalid_pc  = 1'($urandom);
    i_branch_cond = 1'($urandom);
    i_dm_ack      = 1'($urandom);
  endtask

  task automatic quiet(input string ph);
    chk1({ph, "_mem_req"}, o_mem_req, 1'b0);
    chk1({ph, "_mem_wen"}, o_mem_wen, 1'b0);
    chk1({ph, "_rd_wen"}, o_rd_wen, 1'b0);
    chk1({ph, "_fd_wen"}, o_fd_wen, 1'b0);
    chkv({ph, "_retired"}, int'(o_retired), exp_ret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    noise();
    @(negedge clk);
    noise();
    #1;
    exp_ret = 0;
    quiet("rst");
    chk1("rst_mem_sel", o_mem_sel, 1'b0);
    chk1("rst_lw_sel", o_lw_sel, 1'b0);
    chk1("rst_i_en", o_reg_i_en, 1'b0);
    chk1("rst_d_en", o_reg_d_en, 1'b0);
    chk1("rst_a_en", o_reg_a_en, 1'b0);
    chk1("rst_n_en", o_reg_n_en, 1'b0);
    chk1("rst_rf2", o_imm_rf2_sel, 1'b0);
    chk1("rst_branch", o_branch, 1'b0);
    chkv("rst_opcode", int'(o_opcode), 0);
    chkv("rst_func7", int'(o_func7), 0);
    chkv("rst_func3", int'(o_func3), 0);
    chkv("rst_status", int'(o_status), 0);
    chk1("rst_status_valid", o_status_valid, 1'b0);
    i_rst = 1'b0;
    #1;
    quiet("idle");
    chk1("idle_status_valid", o_status_valid, 1'b0);
    chk1("idle_i_en", o_reg_i_en, 1'b0);
  endtask

  task automatic check_end(input logic [2:0] st);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      noise();
      #1;
      quiet("end");
      chk1("end_status_valid", o_status_valid, 1'b1);
      chkv("end_status", int'(o_status), int'(st));
      chk1("end_mem_sel", o_mem_sel, 1'b0);
    end
  endtask

  // Walks one instruction through its expected cycle schedule, starting in FETCH.
  // ack_at: MEM cycle (1-based) carrying the ack, 0 for none; abort_mem: MEM cycle to stop in.
  task automatic run_instr(input vec_t v, input logic br, input logic inv_alu,
                           input logic inv_pc, input int ack_at, input int abort_mem,
                           output bit ended);
    ended = 1'b0;
    for (int c = 0; c <= int'(FW_A); c++) begin
      @(negedge clk);
      noise();
      #1;
      quiet("fetch");
      chk1("fetch_i_en", o_reg_i_en, c == int'(FW_A));
      chk1("fetch_mem_sel", o_mem_sel, 1'b0);
      chk1("fetch_status_valid", o_status_valid, 1'b0);
    end
    @(negedge clk);
    noise();
    i_opcode = v.op;
    i_func7  = v.f7;
    i_func3  = v.f3;
    #1;
    quiet("decode");
    chk1("decode_d_en", o_reg_d_en, 1'b1);
    chk1("decode_i_en", o_reg_i_en, 1'b0);
    @(negedge clk);
    noise();
    i_invalid_alu = inv_alu;
    i_branch_cond = br;
    #1;
    quiet("exec");
    chk1("exec_a_en", o_reg_a_en, 1'b1);
    chkv("exec_opcode", int'(o_opcode), int'(v.op));
    chkv("exec_func7", int'(o_func7), int'(v.f7));
    chkv("exec_func3", int'(o_func3), int'(v.f3));
    chk1("exec_rf2", o_imm_rf2_sel, v.rf2);
    if (inv_alu) begin
      check_end(ST_INV);
      ended = 1'b1;
      return;
    end
    if (v.op == OP_EOF) begin
      check_end(ST_EOF);
      ended = 1'b1;
      return;
    end
    if (v.mem) begin
      for (int k = 1; k <= int'(DMT_A); k++) begin
        @(negedge clk);
        noise();
        i_dm_ack = (k == ack_at);
        #1;
        chk1("mem_sel", o_mem_sel, 1'b1);
        chk1("mem_req", o_mem_req, 1'b1);
        chk1("mem_wen", o_mem_wen, v.wen);
        chk1("mem_rd_wen", o_rd_wen, 1'b0);
        chk1("mem_fd_wen", o_fd_wen, 1'b0);
        if (k == abort_mem) begin
          ended = 1'b1;
          return;
        end
        if (k == ack_at) break;
        if (k == int'(DMT_A)) begin
          check_end(ST_INV);
          ended = 1'b1;
          return;
        end
      end
    end
    @(negedge clk);
    noise();
    #1;
    chk1("wb_rd_wen", o_rd_wen, v.rd);
    chk1("wb_fd_wen", o_fd_wen, v.fd);
    chk1("wb_lw_sel", o_lw_sel, v.lws);
    chk1("wb_mem_req", o_mem_req, 1'b0);
    chk1("wb_mem_wen", o_mem_wen, 1'b0);
    @(negedge clk);
    noise();
    i_invalid_pc = inv_pc;
    #1;
    quiet("npc");
    chk1("npc_n_en", o_reg_n_en, 1'b1);
    chk1("npc_status_valid", o_status_valid, !inv_pc);
    if (!inv_pc) chkv("npc_status", int'(o_status), int'(v.st));
    chk1("npc_branch", o_branch, br && (v.op == OP_B));
    if (inv_pc) begin
      check_end(ST_INV);
      ended = 1'b1;
      return;
    end
    if (exp_ret < (1 << ICW_A) - 1) exp_ret++;
  endtask

  initial begin
    bit   ended;
    vec_t v;
    int   idx;

    tbl[0]  = '{OP_ADDI, 7'h00,      3'b000, N, N, Y, N, N, N, ST_I};
    tbl[1]  = '{OP_R,    7'h00,      3'b000, N, N, Y, N, N, Y, ST_R};
    tbl[2]  = '{OP_R,    7'b0100000, 3'b000, N, N, Y, N, N, Y, ST_R};
    tbl[3]  = '{OP_LW,   7'h00,      3'b010, Y, N, Y, N, Y, N, ST_I};
    tbl[4]  = '{OP_FLW,  7'h00,      3'b010, Y, N, N, Y, Y, N, ST_I};
    tbl[5]  = '{OP_SW,   7'h00,      3'b010, Y, Y, N, N, N, N, ST_S};
    tbl[6]  = '{OP_FSW,  7'h00,      3'b010, Y, Y, N, N, N, N, ST_S};
    tbl[7]  = '{OP_SW,   7'h00,      3'b000, Y, N, N, N, N, N, ST_S};
    tbl[8]  = '{OP_FP,   7'b0000000, 3'b000, N, N, N, Y, N, Y, ST_R};
    tbl[9]  = '{OP_FP,   7'b0000100, 3'b000, N, N, N, Y, N, Y, ST_R};
    tbl[10] = '{OP_FP,   7'b1110000, 3'b001, N, N, Y, N, N, Y, ST_R};
    tbl[11] = '{OP_FP,   7'b1010000, 3'b001, N, N, Y, N, N, Y, ST_R};
    tbl[12] = '{OP_FP,   7'b0000000, 3'b001, N, N, N, N, N, Y, ST_R};
    tbl[13] = '{OP_B,    7'h00,      3'b000, N, N, N, N, N, Y, ST_B};
    tbl[14] = '{OP_LUI,  7'h00,      3'b000, N, N, N, N, N, N, ST_NONE};

    do_reset();

    // Longer fetch latency: 4 FETCH cycles, strobe only in the last, then DECODE.
    for (int c = 0; c <= int'(FW_B) + 1; c++) begin
      @(negedge clk);
      noise();
      #1;
      if (c <= int'(FW_B)) begin
        chk1("b_fetch_i_en", b_reg_i_en, c == int'(FW_B));
        chk1("b_fetch_mem_sel", b_mem_sel, 1'b0);
      end else begin
        chk1("b_decode_d_en", b_reg_d_en, 1'b1);
      end
    end
    do_reset();

    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i], 1'b0, 1'b0, 1'b0, 1 + (i % 3), 0, ended);
      if (ended) do_reset();
    end

    run_instr(tbl[3], 1'b0, 1'b0, 1'b0, 3, 0, ended);            // lw, ack in 3rd MEM cycle
    run_instr(tbl[3], 1'b0, 1'b0, 1'b0, int'(DMT_A), 0, ended);  // ack coincides with timeout
    run_instr(tbl[13], 1'b1, 1'b0, 1'b0, 0, 0, ended);           // taken beq
    run_instr(tbl[5], 1'b0, 1'b0, 1'b0, 0, 0, ended);            // sw timeout -> END
    do_reset();
    run_instr(ref_vec(OP_EOF, 7'h00, 3'b000), 1'b0, 1'b0, 1'b0, 0, 0, ended);
    do_reset();
    run_instr(tbl[0], 1'b0, 1'b0, 1'b1, 0, 0, ended);            // invalid next PC
    do_reset();
    run_instr(ref_vec(OP_EOF, 7'h00, 3'b000), 1'b0, 1'b1, 1'b0, 0, 0, ended);
    do_reset();
    run_instr(tbl[0], 1'b0, 1'b0, 1'b0, 0, 0, ended);
    run_instr(tbl[1], 1'b0, 1'b0, 1'b0, 0, 0, ended);
    run_instr(tbl[3], 1'b0, 1'b0, 1'b0, 0, 2, ended);            // reset in mid-MEM
    do_reset();
    for (int i = 0; i < 18; i++) begin                            // counter saturation
      run_instr(tbl[0], 1'b0, 1'b0, 1'b0, 0, 0, ended);
    end
    do_reset();

    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 15);
      if (idx == 15) v = ref_vec(OP_EOF, 7'($urandom), 3'($urandom));
      else v = ref_vec(tbl[idx].op, tbl[idx].f7, tbl[idx].f3);
      run_instr(v, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 5), 0, ended);
      if (ended) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
